// File: rtl/edf_ic_pkg.sv
// Shared types and constants for the EDF interrupt controller.
// Holds the gateway state encoding, config register map and CTRL bit positions.
package edf_ic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  localparam logic [1:0] GW_CTRL   = 2'd0;
  localparam logic [1:0] GW_OFFSET = 2'd1;
  localparam logic [1:0] GW_TS_LO  = 2'd2;
  localparam logic [1:0] GW_TS_HI  = 2'd3;

  localparam int GW_EN   = 0;
  localparam int GW_TRIG = 1;
  localparam int GW_OVR  = 2;

endpackage

// File: rtl/edf_gw_trigger.sv
// Trigger detector for one gateway source: level or rising-edge, gated by enable.
// irq_q remembers the previous irq sample so a held-high line yields a single edge.
module edf_gw_trigger (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq,
  input  logic en,
  input  logic trig,
  output logic trig_ev
);

  logic irq_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq;
  end

  assign trig_ev = en & irq & (~trig | ~irq_q);

endmodule

// File: rtl/edf_gateway_cell.sv
// Per-source EDF interrupt gateway: timestamps triggers, presents ts + offset as the
// absolute deadline, and runs the pending/claimed/completed handshake with a one-deep edge queue.
module edf_gateway_cell
  import edf_ic_pkg::*;
#(
  parameter int TsWidth     = 64,
  parameter int OffsetWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [63:0]        mtime_i,
  input  logic               irq_i,
  input  logic               cfg_req_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  input  logic               claim_i,
  input  logic               complete_i,
  output logic [TsWidth-1:0] dl_o,
  output logic               ip_o,
  output logic               ovr_o
);

  gw_state_e              state_q, state_d;
  logic [TsWidth-1:0]     ts_q, ts_d;
  logic [TsWidth-1:0]     qts_q, qts_d;
  logic                   queued_q, queued_d;
  logic [OffsetWidth-1:0] offset_q;
  logic                   en_q, trig_q, ovr_q;
  logic                   ovr_set;

  logic               trig_ev;
  logic               cfg_wr, ctrl_wr, offset_wr, en_clr, edge_ev;
  logic [TsWidth-1:0] mtime;
  logic [63:0]        ts_ext;

  assign mtime     = mtime_i[TsWidth-1:0];
  assign cfg_wr    = cfg_req_i & cfg_we_i;
  assign ctrl_wr   = cfg_wr & (cfg_addr_i == GW_CTRL);
  assign offset_wr = cfg_wr & (cfg_addr_i == GW_OFFSET);
  assign en_clr    = ctrl_wr & ~cfg_wdata_i[GW_EN];
  // Only edges can be queued or overrun; a disable in the same cycle discards them.
  assign edge_ev   = trig_ev & trig_q & ~en_clr;

  edf_gw_trigger u_trigger (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .irq     (irq_i),
    .en      (en_q),
    .trig    (trig_q),
    .trig_ev (trig_ev)
  );

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    qts_d    = qts_q;
    queued_d = queued_q;
    ovr_set  = 1'b0;
    case (state_q)
      GW_IDLE: begin
        if (trig_ev) begin
          state_d = GW_PENDING;
          ts_d    = mtime;
        end
      end
      GW_PENDING: begin
        if (en_clr) begin
          state_d = GW_IDLE;
        end else begin
          ovr_set = trig_ev & trig_q;
          if (claim_i) state_d = GW_ACTIVE;
        end
      end
      GW_ACTIVE: begin
        if (en_clr) queued_d = 1'b0;
        if (complete_i) begin
          if (queued_q && !en_clr) begin
            state_d  = GW_PENDING;
            ts_d     = qts_q;
            queued_d = 1'b0;
            ovr_set  = edge_ev;
          end else if (edge_ev) begin
            state_d = GW_PENDING;
            ts_d    = mtime;
          end else begin
            state_d = GW_IDLE;
          end
        end else if (edge_ev) begin
          if (queued_q) begin
            ovr_set = 1'b1;
          end else begin
            qts_d    = mtime;
            queued_d = 1'b1;
          end
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  // NOTE: the async reset clears every register here, including the queued timestamp.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= GW_IDLE;
      ts_q     <= '0;
      qts_q    <= '0;
      queued_q <= 1'b0;
      offset_q <= '0;
      en_q     <= 1'b0;
      trig_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      qts_q    <= qts_d;
      queued_q <= queued_d;
      if (offset_wr) offset_q <= cfg_wdata_i[OffsetWidth-1:0];
      if (ctrl_wr) begin
        en_q   <= cfg_wdata_i[GW_EN];
        trig_q <= cfg_wdata_i[GW_TRIG];
      end
      // A new overrun beats a software clear in the same cycle.
      ovr_q <= ovr_set | (ovr_q & ~(ctrl_wr & cfg_wdata_i[GW_OVR]));
    end
  end

  assign ts_ext = 64'(ts_q);

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_req_i && !cfg_we_i) begin
      case (cfg_addr_i)
        GW_CTRL:   cfg_rdata_o = {29'd0, ovr_q, trig_q, en_q};
        GW_OFFSET: cfg_rdata_o = 32'(offset_q);
        GW_TS_LO:  cfg_rdata_o = ts_ext[31:0];
        default:   cfg_rdata_o = ts_ext[63:32];
      endcase
    end
  end

  assign dl_o  = ts_q + TsWidth'(offset_q);
  assign ip_o  = (state_q == GW_PENDING);
  assign ovr_o = ovr_q;

endmodule

// File: tb/tb_edf_gateway_cell.sv
// Directed and randomized checks for edf_gateway_cell against a queue-based behavioural model.
// Inputs change #1 after the rising edge; outputs are sampled before the next edge.
module tb_edf_gateway_cell;
  import edf_ic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] mtime;
  logic        irq, cfg_req, cfg_we, claim, complete;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [63:0] dl;
  logic        ip, ovr;

  int n_checks = 0;
  int n_fail   = 0;

  edf_gateway_cell #(.TsWidth(64), .OffsetWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mtime_i     (mtime),
    .irq_i       (irq),
    .cfg_req_i   (cfg_req),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .claim_i     (claim),
    .complete_i  (complete),
    .dl_o        (dl),
    .ip_o        (ip),
    .ovr_o       (ovr)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = addr;
    #1;
    data = cfg_rdata;
    cfg_req = 1'b0;
  endtask

  task automatic pulse_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic pulse_complete();
    complete = 1'b1; tick(); complete = 1'b0;
  endtask

  // Behavioural model: a phase, the presented timestamp and a queue of waiting edge timestamps.
  typedef enum {M_IDLE, M_WAIT, M_SERVE} m_phase_e;
  m_phase_e    m_phase;
  logic [63:0] m_ts;
  logic [63:0] m_q[$];
  logic [31:0] m_off;
  bit          m_en, m_trig, m_ovr, m_prev_irq;

  function automatic void model_reset();
    m_phase = M_IDLE; m_ts = '0; m_q.delete(); m_off = '0;
    m_en = 0; m_trig = 0; m_ovr = 0; m_prev_irq = 0;
  endfunction

  function automatic void model_step();
    bit ev, wr_ctrl, en_off, edge_hit, overrun;
    ev       = m_en && irq && (!m_trig || !m_prev_irq);
    wr_ctrl  = cfg_req && cfg_we && (cfg_addr == GW_CTRL);
    en_off   = wr_ctrl && !cfg_wdata[0];
    edge_hit = ev && m_trig && !en_off;
    overrun  = 0;
    case (m_phase)
      M_IDLE: if (ev) begin m_phase = M_WAIT; m_ts = mtime; end
      M_WAIT: begin
        if (en_off) m_phase = M_IDLE;
        else begin
          if (ev && m_trig) overrun = 1;
          if (claim) m_phase = M_SERVE;
        end
      end
      default: begin
        if (en_off) m_q.delete();
        if (complete) begin
          if (m_q.size() > 0) begin
            m_ts = m_q.pop_front(); m_phase = M_WAIT;
            if (edge_hit) overrun = 1;
          end else if (edge_hit) begin
            m_ts = mtime; m_phase = M_WAIT;
          end else m_phase = M_IDLE;
        end else if (edge_hit) begin
          if (m_q.size() > 0) overrun = 1;
          else m_q.push_back(mtime);
        end
      end
    endcase
    m_prev_irq = irq;
    m_ovr = overrun || (m_ovr && !(wr_ctrl && cfg_wdata[2]));
    if (wr_ctrl) begin m_en = cfg_wdata[0]; m_trig = cfg_wdata[1]; end
    if (cfg_req && cfg_we && cfg_addr == GW_OFFSET) m_off = cfg_wdata;
  endfunction

  logic [31:0] rd;

  initial begin
    rst_ni = 1'b0; mtime = '0; irq = 0; cfg_req = 0; cfg_we = 0; cfg_addr = '0;
    cfg_wdata = '0; claim = 0; complete = 0;
    repeat (2) tick();
    check("reset_ip", 64'(ip), 64'd0);
    check("reset_dl", dl, 64'd0);
    check("reset_ovr", 64'(ovr), 64'd0);
    check("idle_rdata", 64'(cfg_rdata), 64'd0);
    rst_ni = 1'b1;
    tick();

    // 1: level trigger at mtime 1000 with offset 100
    cfg_write(GW_CTRL, 32'h1);
    cfg_write(GW_OFFSET, 32'd100);
    mtime = 64'd1000; irq = 1; tick();
    check("t1_ip", 64'(ip), 64'd1);
    check("t1_dl", dl, 64'd1100);
    cfg_read(GW_TS_LO, rd); check("t1_ts_lo", 64'(rd), 64'd1000);
    cfg_read(GW_TS_HI, rd); check("t1_ts_hi", 64'(rd), 64'd0);

    // 2: claim/complete with level held high, then retrigger
    mtime = 64'd1001; pulse_claim();
    check("t2_ip_claimed", 64'(ip), 64'd0);
    mtime = 64'd1005; pulse_complete();
    check("t2_ip_idle", 64'(ip), 64'd0);
    mtime = 64'd1006; tick();
    check("t2_ip_retrig", 64'(ip), 64'd1);
    check("t2_dl_retrig", dl, 64'd1106);
    cfg_read(GW_TS_LO, rd); check("t2_ts_lo", 64'(rd), 64'd1006);
    irq = 0; pulse_claim(); pulse_complete();
    check("t2_ip_done", 64'(ip), 64'd0);
    tick();
    check("t2_no_retrig", 64'(ip), 64'd0);

    // 3: edge while claimed is queued and presented after complete
    cfg_write(GW_CTRL, 32'h3);
    mtime = 64'd50; irq = 1; tick();
    check("t3_ip", 64'(ip), 64'd1);
    check("t3_dl", dl, 64'd150);
    irq = 0; mtime = 64'd55; pulse_claim();
    mtime = 64'd60; irq = 1; tick();
    check("t3_ip_active", 64'(ip), 64'd0);
    irq = 0; mtime = 64'd70; pulse_complete();
    check("t3_ip_requeued", 64'(ip), 64'd1);
    check("t3_dl_requeued", dl, 64'd160);
    check("t3_ovr", 64'(ovr), 64'd0);
    pulse_claim(); pulse_complete();
    check("t3_queue_empty", 64'(ip), 64'd0);

    // 4: second edge while pending keeps ts and raises overrun
    mtime = 64'd10; irq = 1; tick();
    irq = 0; tick();
    mtime = 64'd20; irq = 1; tick();
    check("t4_ovr_set", 64'(ovr), 64'd1);
    check("t4_dl_kept", dl, 64'd110);
    cfg_read(GW_TS_LO, rd); check("t4_ts_kept", 64'(rd), 64'd10);
    irq = 0; cfg_write(GW_CTRL, 32'h7);
    check("t4_ovr_clr", 64'(ovr), 64'd0);
    cfg_read(GW_CTRL, rd); check("t4_ctrl", 64'(rd), 64'd3);
    mtime = 64'd30; irq = 1; cfg_write(GW_CTRL, 32'h7);
    check("t4_set_wins", 64'(ovr), 64'd1);
    irq = 0; cfg_write(GW_CTRL, 32'h2);
    check("t4_disable_idle", 64'(ip), 64'd0);
    cfg_read(GW_CTRL, rd); check("t4_ctrl_dis", 64'(rd), 64'd6);
    cfg_write(GW_CTRL, 32'h7);
    check("t4_ovr_clr2", 64'(ovr), 64'd0);

    // 5: deadline wraps modulo 2^64
    cfg_write(GW_OFFSET, 32'hFFFF_FFFF);
    mtime = 64'hFFFF_FFFF_FFFF_FFF0; irq = 1; tick();
    check("t5_ip", 64'(ip), 64'd1);
    check("t5_dl_wrap", dl, 64'h0000_0000_FFFF_FFEF);
    cfg_read(GW_TS_HI, rd); check("t5_ts_hi", 64'(rd), 64'hFFFF_FFFF);
    cfg_read(GW_OFFSET, rd); check("t5_offset", 64'(rd), 64'hFFFF_FFFF);
    cfg_write(GW_TS_LO, 32'h1234);
    cfg_read(GW_TS_LO, rd); check("t5_ts_ro", 64'(rd), 64'hFFFF_FFF0);

    // 6: reset while active with a queued edge
    irq = 0; pulse_claim();
    mtime = 64'h100; irq = 1; tick();
    irq = 0; tick();
    #2 rst_ni = 1'b0; #1;
    check("t6_ip", 64'(ip), 64'd0);
    check("t6_dl", dl, 64'd0);
    check("t6_ovr", 64'(ovr), 64'd0);
    cfg_read(GW_CTRL, rd);   check("t6_ctrl", 64'(rd), 64'd0);
    cfg_read(GW_OFFSET, rd); check("t6_offset", 64'(rd), 64'd0);
    cfg_read(GW_TS_LO, rd);  check("t6_ts_lo", 64'(rd), 64'd0);
    cfg_read(GW_TS_HI, rd);  check("t6_ts_hi", 64'(rd), 64'd0);
    tick();
    rst_ni = 1'b1; irq = 1; claim = 1; complete = 1; tick();
    claim = 0; complete = 0; repeat (3) tick();
    check("t6_no_spurious", 64'(ip), 64'd0);
    cfg_write(GW_CTRL, 32'h3); tick();
    check("t6_held_no_edge", 64'(ip), 64'd0);
    irq = 0; tick();
    mtime = 64'h200; irq = 1; tick();
    check("t6_alive", 64'(ip), 64'd1);
    check("t6_alive_dl", dl, 64'h200);

    // Randomized phase against the behavioural model
    rst_ni = 1'b0; irq = 0; tick();
    rst_ni = 1'b1; model_reset(); mtime = 64'd5000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      if ($urandom_range(0, 99) < 40) irq = ~irq;
      claim    = ($urandom_range(0, 99) < 25);
      complete = ($urandom_range(0, 99) < 25);
      mtime    = mtime + 64'($urandom_range(1, 5));
      r = $urandom_range(0, 99);
      cfg_req = 0; cfg_we = 0;
      if (r < 4) begin
        cfg_req = 1; cfg_we = 1; cfg_addr = GW_CTRL;
        cfg_wdata = {$urandom_range(0, 1) == 1 ? 30'h3FFF_FFFF : 30'd0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 85)};
      end else if (r < 7) begin
        cfg_req = 1; cfg_we = 1; cfg_addr = GW_OFFSET; cfg_wdata = $urandom;
      end else if (r < 9) begin
        cfg_req = 1; cfg_we = 1; cfg_addr = 2'($urandom_range(2, 3)); cfg_wdata = $urandom;
      end
      model_step();
      tick();
      cfg_req = 0; cfg_we = 0;
      check("rnd_ip", 64'(ip), 64'(m_phase == M_WAIT));
      check("rnd_dl", dl, m_ts + 64'(m_off));
      check("rnd_ovr", 64'(ovr), 64'(m_ovr));
      if (cyc % 8 == 0) begin
        cfg_read(GW_CTRL, rd);  check("rnd_ctrl", 64'(rd), {61'd0, m_ovr, m_trig, m_en});
        cfg_read(GW_TS_LO, rd); check("rnd_ts_lo", 64'(rd), 64'(m_ts[31:0]));
        cfg_read(GW_TS_HI, rd); check("rnd_ts_hi", 64'(rd), 64'(m_ts[63:32]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
